// File: rtl/px_frame_readout_ctrl.sv
// Pixel frame sequencer: erase/expose/convert/read phases, per-row capture, valid/ready word stream (stall holds word).
// Row word 0 is presented the cycle after the last read cycle. GRAY_RAMP_EN: Gray ramp, captured words decoded to binary.
module px_frame_readout_ctrl #(
  parameter int N_ROWS     = 3,
  parameter int N_COLS     = 3,
  parameter int DW         = 8,
  parameter int C_ERASE    = 5,
  parameter int C_EXPOSE   = 255,
  parameter int C_READ     = 5,
  parameter bit CONTINUOUS = 1'b0,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic                 read,
  output logic [RW-1:0]        row_sel,
  output logic [DW-1:0]        ramp_cnt,
  input  logic [N_COLS*DW-1:0] px_data,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CLW      = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CONV_LEN = 1 << DW;
  localparam int M1       = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int M2       = (M1 > C_READ) ? M1 : C_READ;
  localparam int CMAX     = (M2 > CONV_LEN) ? M2 : CONV_LEN;
  // Sized so the convert count never wraps inside the phase.
  localparam int CW       = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  ERASE_END  = CW'(C_ERASE - 1);
  localparam logic [CW-1:0]  EXPOSE_END = CW'(C_EXPOSE - 1);
  localparam logic [CW-1:0]  CONV_END   = CW'(CONV_LEN - 1);
  localparam logic [CW-1:0]  READ_END   = CW'(C_READ - 1);
  localparam logic [CLW-1:0] COL_MAX    = CLW'(N_COLS - 1);
  localparam logic [RW-1:0]  ROW_MAX    = RW'(N_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CW-1:0]              cnt;
  logic [RW-1:0]              row;
  logic [CLW-1:0]             col;
  logic [N_COLS-1:0][DW-1:0]  rbuf;
  logic                       accept;
  logic                       col_last;
  logic                       row_last;
  logic [DW-1:0]              ramp_bin;

  function automatic logic [DW-1:0] cap_word(input logic [DW-1:0] w);
`ifdef GRAY_RAMP_EN
    logic [DW-1:0] b;
    b[DW-1] = w[DW-1];
    for (int i = DW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ w[i];
    end
    return b;
`else
    return w;
`endif
  endfunction

  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);
  assign accept   = (state == S_DRAIN) && out_ready;
  assign ramp_bin = cnt[DW-1:0];
  assign row_sel  = row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    erase     = 1'b0;
    expose    = 1'b0;
    convert   = 1'b0;
    read      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    ramp_cnt  = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ERASE;
      end
      S_ERASE: begin
        erase = 1'b1;
        if (cnt == ERASE_END) state_nxt = S_EXPOSE;
      end
      S_EXPOSE: begin
        expose = 1'b1;
        if (cnt == EXPOSE_END) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        convert = 1'b1;
`ifdef GRAY_RAMP_EN
        ramp_cnt = ramp_bin ^ (ramp_bin >> 1);
`else
        ramp_cnt = ramp_bin;
`endif
        if (cnt == CONV_END) state_nxt = S_READ;
      end
      S_READ: begin
        read = 1'b1;
        if (cnt == READ_END) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = rbuf[col];
        out_last  = row_last && col_last;
        if (accept && col_last) begin
          if (!row_last)       state_nxt = S_READ;
          else if (CONTINUOUS) state_nxt = S_ERASE;
          else                 state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      rbuf       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state inside {S_ERASE, S_EXPOSE, S_CONVERT, S_READ}) begin
        cnt <= cnt + CW'(1);
      end
      // Column bus is only trusted on the final read cycle.
      if (state == S_READ && cnt == READ_END) begin
        for (int c = 0; c < N_COLS; c++) begin
          rbuf[c] <= cap_word(px_data[c*DW +: DW]);
        end
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CLW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_px_frame_readout_ctrl.sv
// Directed bench for px_frame_readout_ctrl: one-shot instance plus a CONTINUOUS=1 instance sharing clk/rst/start.
module tb_px_frame_readout_ctrl;

  localparam int NC = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b1;
  logic out_ready = 1'b0;

  logic erase, expose, convert, read, out_valid, out_last, busy, frame_done;
  logic [1:0] row_sel;
  logic [DW-1:0] ramp_cnt, out_data;
  logic [NC*DW-1:0] px_data;

  logic c_erase, c_expose, c_convert, c_read, c_out_valid, c_out_last, c_busy, c_frame_done;
  logic [1:0] c_row_sel;
  logic [DW-1:0] c_ramp_cnt, c_out_data;
  logic [NC*DW-1:0] c_px_data;

  logic [7:0] words [9] = '{8'h80, 8'h50, 8'h70, 8'h90, 8'h40, 8'h10, 8'h55, 8'h67, 8'h30};

  int vectors = 0;
  int miscompares = 0;
  int multi = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_RAMP_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  function automatic logic [NC*DW-1:0] row_px(input logic [1:0] r);
    logic [NC*DW-1:0] v;
    v = '0;
    if (r < 2'd3) begin
      for (int c = 0; c < NC; c++) v[c*DW +: DW] = enc(words[int'(r)*NC + c]);
    end
    return v;
  endfunction

  assign px_data   = row_px(row_sel);
  assign c_px_data = row_px(c_row_sel);

  px_frame_readout_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .row_sel(row_sel), .ramp_cnt(ramp_cnt), .px_data(px_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  px_frame_readout_ctrl #(.CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .rst(rst), .start(start),
    .erase(c_erase), .expose(c_expose), .convert(c_convert), .read(c_read),
    .row_sel(c_row_sel), .ramp_cnt(c_ramp_cnt), .px_data(c_px_data),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(1'b1),
    .out_last(c_out_last), .busy(c_busy), .frame_done(c_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic take(input logic [7:0] w, input logic lst, input string tag);
    int b;
    b = 0;
    while (!out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_dat"}, out_data, w);
    chk({tag, "_last"}, out_last, lst);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_strobes"}, {erase, expose, convert, read}, 0);
    chk({tag, "_row_sel"}, row_sel, 0);
    chk({tag, "_ramp"}, ramp_cnt, 0);
    chk({tag, "_stream"}, {out_valid, out_last, frame_done}, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_c_all"}, {c_erase, c_expose, c_convert, c_read, c_out_valid, c_busy, c_frame_done}, 0);
  endtask

  always @(negedge clk) begin
    if ($countones({erase, expose, convert, read}) > 1) multi++;
    if ($countones({c_erase, c_expose, c_convert, c_read}) > 1) multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, err, b;
    logic [7:0] hold;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_wait", busy, 0);

    // Phase lengths and ramp
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (erase && n < 1000) begin n++; @(negedge clk); end
    chk("erase_len", n, 5);
    chk("expose_after_erase", expose, 1);
    n = 0;
    while (expose && n < 1000) begin
      if (ramp_cnt != 0) n += 1000;
      n++;
      @(negedge clk);
    end
    chk("expose_len", n, 255);
    n = 0; err = 0;
    while (convert && n < 1000) begin
      if (ramp_cnt !== enc(8'(n))) err++;
      n++;
      @(negedge clk);
    end
    chk("convert_len", n, 256);
    chk("ramp_seq_errs", err, 0);
    chk("ramp_after_convert", ramp_cnt, 0);
    chk("read_row0", read, 1);
    n = 0; err = 0;
    while (read && n < 100) begin
      if (row_sel != 2'd0 || out_valid) err++;
      n++;
      @(negedge clk);
    end
    chk("read_len", n, 5);
    chk("read_row0_sel", err, 0);

    // Stream with a stall on word 40
    take(8'h80, 1'b0, "w0");
    take(8'h50, 1'b0, "w1");
    take(8'h70, 1'b0, "w2");
    chk("read_after_row0", read, 1);
    chk("row_sel_row1", row_sel, 1);
    take(8'h90, 1'b0, "w3");
    out_ready = 1'b0;
    hold = out_data;
    err = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== 8'h40 || read || out_last) err++;
    end
    chk("stall_word", hold, 8'h40);
    chk("stall_hold_errs", err, 0);
    take(8'h40, 1'b0, "w4");
    take(8'h10, 1'b0, "w5");
    take(8'h55, 1'b0, "w6");
    take(8'h67, 1'b0, "w7");
    take(8'h30, 1'b1, "w8");
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_after_frame", busy, 0);
    chk("valid_after_frame", out_valid, 0);
    chk("row_sel_idle", row_sel, 0);
    @(negedge clk);
    chk("frame_done_single", frame_done, 0);

    // Reset mid-convert
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (!(convert && ramp_cnt == enc(8'd100)) && b < 2000) begin @(negedge clk); b++; end
    chk("reach_ramp100", convert, 1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("cont_waits_after_rst", {c_busy, c_erase}, 0);
    chk("dut_waits_after_rst", busy, 0);

    // Continuous restart versus one-shot
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (!c_frame_done && b < 2000) begin @(negedge clk); b++; end
    chk("cont_frame_done", c_frame_done, 1);
    chk("cont_erase_in_fd", c_erase, 1);
    chk("cont_busy_in_fd", c_busy, 1);
    chk("oneshot_fd", frame_done, 1);
    chk("oneshot_idle", {busy, erase}, 0);
    @(negedge clk);
    chk("cont_erase_next", c_erase, 1);

    chk("strobe_exclusive", multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
